uart_rx_mmio: RTL and testbench
===============================

# uart_rx_mmio

Memory-mapped UART receiver on the PicoRV32 native memory bus. It is the receive-side counterpart of the write-only UART sink at 0x02000000. The block deserializes an 8N1 line into an 8-entry FIFO that firmware drains through register reads, and raises an interrupt while data is pending. The system address decoder places it in the 0x02000000 region and qualifies `sel`.

## Interface
Parameters:
- `DEFAULT_DIV`, 16: reset value of the DIV register, in clk cycles per bit.
- `FIFO_DEPTH_LOG2`, 3: FIFO depth is 2^N entries.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `sel`  in  1  `mem_valid` qualified by the address decode for this block.
- `mem_addr`  in  4  byte offset; only bits [3:2] are decoded.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; all-zero means read.
- `mem_rdata`  out  32  read data; reset 0.
- `mem_ready`  out  1  single-cycle acknowledge; reset 0.
- `rx`  in  1  asynchronous serial input; idles high.
- `irq`  out  1  high while the FIFO is non-empty; reset 0.

## Operation
Registers:
- 0x0 DATA (RO)
  - Read returns {24'h0, byte} and pops the FIFO.
  - Read when empty returns 32'hFFFF_FFFF with no pop.
  - Writes are ignored.
- 0x4 STATUS
  - Bit 0: not-empty. Bit 1: overrun (sticky). Bit 2: frame error (sticky).
  - Bits [7:4]: FIFO count, 0..8. Other bits read 0.
  - A write with `mem_wstrb[0]` set clears bits 1 and 2 wherever `mem_wdata` holds a 1 (W1C).
- 0x8 DIV (RW)
  - Bits [15:0] hold the bit period.
  - A written value below 4 is stored as 4. Reset value is `DEFAULT_DIV`.
- 0xC: reads 0, writes ignored.

Receiver:
- `rx` passes through a 2-flop synchronizer set to 1 on reset.
- The FSM has states IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synchronized falling edge loads the counter with DIV/2 and moves to START.
  - START: at counter expiry, sample the line. Low: reload DIV, go to DATA. High: glitch, return to IDLE with nothing recorded.
  - DATA: sample every DIV cycles, LSB first, 8 bits, then go to STOP.
  - STOP: sample after DIV cycles.
    - Line high: push the byte, go to IDLE.
    - Line low: set frame error, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized line is 1, then go to IDLE.
- A DIV write takes effect at the next counter load. A frame already in progress keeps its current count.

FIFO boundaries:
- Push when full with no pop in the same cycle: drop the new byte, set overrun. Stored data is unchanged.
- Push and pop in the same cycle when full: both succeed, no overrun, count stays 8.
- Push and pop in the same cycle when count is 1: popped data is the old head, count stays 1.
- Pointers wrap modulo 2^N. An extra count bit distinguishes full from empty.

Reset, including mid-frame:
- FSM returns to IDLE; FIFO is emptied.
- Flags clear, DIV returns to `DEFAULT_DIV`.
- `mem_ready`, `irq` and `mem_rdata` go to 0.

## Timing
- Bus:
  - `mem_ready` is registered and asserts the cycle after `sel`.
  - `mem_rdata` is valid in the same cycle as `mem_ready`.
  - `sel` is ignored while `mem_ready` is high, so there is no double-accept.
  - Pop and W1C take effect at the `mem_ready` edge.
- RX latency:
  - The synchronizer adds 2 cycles.
  - START is sampled DIV/2 cycles after the detected edge.
  - The push occurs at the clock edge of the stop sample; count and `irq` are updated the following cycle.
  - A frame occupies roughly 9.5×DIV cycles from edge detect to push.
- A STATUS read returns values registered before the read's own pop or clear.

## Structure
- `uart_pkg` holds:
  - Register offsets: `REG_DATA`, `REG_STATUS`, `REG_DIV`.
  - STATUS bit indices.
  - The `rx_state_t` enum.
  - `DIV_MIN` = 4.
- One sub-module, `uart_rx_core`: synchronizer, FSM, bit counter and shift register. Outputs are a byte strobe, byte data and a frame-error strobe.
- The FIFO and register file live in `uart_rx_mmio`.

## Test plan
- DIV=16, send 0x55 → `irq`=1; STATUS=0x00000011; DATA read=0x00000055; then STATUS=0 and `irq`=0.
- DATA read on an empty FIFO → 32'hFFFF_FFFF; `mem_ready` asserts exactly 1 cycle after `sel`; STATUS is unchanged.
- Send 0x01..0x09 without reading:
  - STATUS=0x00000083.
  - Reads return 0x01..0x08, then 0xFFFFFFFF.
  - Write 0x2 to STATUS → overrun clears.
- Send 0xA5 with stop bit 0 → no push; STATUS bit 2 set; the next valid frame 0x3C is received correctly after the line returns high.
- 3-cycle low glitch on `rx` with DIV=16 → no byte and no flags. Write DIV=2 → DIV reads back 4.
- Assert `resetn` low mid-frame (after bit 3) with 2 bytes queued → STATUS=0, DIV=16, `irq`=0; the next full frame 0x7E is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register map,
// STATUS bit positions, receiver FSM states and the DIV clamp.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_FRAME_ERR = 2;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  // Bit periods shorter than DIV_MIN leave no room for a mid-bit sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < DIV_MIN) ? DIV_MIN : value;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserializer: rx synchronizer, receive FSM, bit-period counter and
// shift register. Emits one-cycle byte and frame-error strobes at the stop sample.
module uart_rx_core
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx,
  input  logic [15:0] div,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  logic      rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t state_r, state_next_s;
  logic [15:0] cnt_r, cnt_next_s;
  logic [2:0]  bit_idx_r, bit_idx_next_s;
  logic [7:0]  shift_r, shift_next_s;
  logic        expire_s;

  assign expire_s = (cnt_r == 16'd0);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // State register together with the counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
    end
  end

  // Next-state logic; the counter is loaded with period-1 and samples on zero.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = expire_s ? cnt_r : (cnt_r - 16'd1);
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    case (state_r)
      IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          state_next_s = START;
          cnt_next_s   = {1'b0, div[15:1]} - 16'd1;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (expire_s && !rx_sync_r) begin
          state_next_s   = DATA;
          cnt_next_s     = div - 16'd1;
          bit_idx_next_s = 3'd0;
        end else if (expire_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (expire_s) begin
          shift_next_s   = {rx_sync_r, shift_r[7:1]};
          cnt_next_s     = div - 16'd1;
          bit_idx_next_s = bit_idx_r + 3'd1;
          state_next_s   = (bit_idx_r == 3'd7) ? STOP : DATA;
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (expire_s) begin
          state_next_s = rx_sync_r ? IDLE : WAIT_HIGH;
        end else begin
          state_next_s = STOP;
        end
      end
      WAIT_HIGH: begin
        if (rx_sync_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_HIGH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output strobes fire on the stop-bit sample cycle.
  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    byte_data  = shift_r;
    if (state_r == STOP && expire_s) begin
      byte_valid = rx_sync_r;
      frame_err  = !rx_sync_r;
    end else begin
      byte_valid = 1'b0;
      frame_err  = 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// PicoRV32 native-bus UART receiver: receive core, byte FIFO, and the
// DATA/STATUS/DIV register file with a registered single-cycle acknowledge.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int DEFAULT_DIV     = 16,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        rx,
  output logic        irq
);

  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL = CW'(1 << FIFO_DEPTH_LOG2);

  logic [7:0]                 fifo_mem_r [1 << FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]              count_r, count_next_s;
  logic        overrun_r, frame_err_r, ready_r, irq_r;
  logic [31:0] rdata_r, rdata_next_s, status_s;
  logic [15:0] div_r, div_wr_s;
  logic [1:0]  reg_sel_s;
  logic        accept_s, is_write_s, empty_s, full_s, pop_s, push_ok_s;
  logic        ovr_set_s, w1c_s, div_we_s;
  logic        byte_valid_s, frame_err_s;
  logic [7:0]  byte_data_s;
  logic        unused_s;

  uart_rx_core u_core (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .div        (div_r),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .frame_err  (frame_err_s)
  );

  assign mem_ready = ready_r;
  assign mem_rdata = rdata_r;
  assign irq       = irq_r;
  assign unused_s  = &{1'b0, mem_addr[1:0], mem_wdata[31:16]};

  // Bus decode, FIFO bookkeeping and read-data mux.
  always_comb begin
    accept_s   = sel && !ready_r;
    is_write_s = |mem_wstrb;
    reg_sel_s  = mem_addr[3:2];
    empty_s    = (count_r == CNT_ZERO);
    full_s     = (count_r == CNT_FULL);
    pop_s      = accept_s && !is_write_s && (reg_sel_s == REG_DATA) && !empty_s;
    push_ok_s  = byte_valid_s && (!full_s || pop_s);
    ovr_set_s  = byte_valid_s && full_s && !pop_s;
    w1c_s      = accept_s && is_write_s && (reg_sel_s == REG_STATUS) && mem_wstrb[0];
    div_we_s   = accept_s && (reg_sel_s == REG_DIV) && (|mem_wstrb[1:0]);
    div_wr_s   = {mem_wstrb[1] ? mem_wdata[15:8] : div_r[15:8],
                  mem_wstrb[0] ? mem_wdata[7:0]  : div_r[7:0]};
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
    status_s = 32'h0;
    status_s[ST_NOT_EMPTY] = !empty_s;
    status_s[ST_OVERRUN]   = overrun_r;
    status_s[ST_FRAME_ERR] = frame_err_r;
    status_s[ST_COUNT_LSB +: 4] = 4'(count_r);
    if (is_write_s) begin
      rdata_next_s = 32'h0;
    end else begin
      case (reg_sel_s)
        REG_DATA:   rdata_next_s = empty_s ? 32'hFFFF_FFFF : {24'h0, fifo_mem_r[rd_ptr_r]};
        REG_STATUS: rdata_next_s = status_s;
        REG_DIV:    rdata_next_s = {16'h0, div_r};
        default:    rdata_next_s = 32'h0;
      endcase
    end
  end

  // Registered acknowledge and read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_r <= 1'b0;
      rdata_r <= 32'h0;
    end else begin
      ready_r <= accept_s;
      rdata_r <= accept_s ? rdata_next_s : 32'h0;
    end
  end

  // FIFO storage; stale contents are harmless because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= byte_data_s;
    end
  end

  // FIFO pointers, occupancy and interrupt.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
      count_r  <= CNT_ZERO;
      irq_r    <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)     rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_next_s;
      irq_r   <= (count_next_s != CNT_ZERO);
    end
  end

  // Sticky flags (a new event wins over a same-cycle clear) and DIV register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      div_r       <= 16'(DEFAULT_DIV);
    end else begin
      overrun_r   <= (overrun_r   && !(w1c_s && mem_wdata[ST_OVERRUN]))   || ovr_set_s;
      frame_err_r <= (frame_err_r && !(w1c_s && mem_wdata[ST_FRAME_ERR])) || frame_err_s;
      if (div_we_s) div_r <= clamp_div(div_wr_s);
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: serial frames on rx, register accesses
// on the bus, every result compared against hand-computed values.
module tb_uart_rx_mmio;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  mem_addr = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        rx = 1'b1;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  uart_rx_mmio #(.DEFAULT_DIV(16), .FIFO_DEPTH_LOG2(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .rx        (rx),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; mem_addr = a; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    check_val("rd_ready", {31'h0, mem_ready}, 32'h1);
    d = mem_rdata;
    sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    check_val("wr_ready", {31'h0, mem_ready}, 32'h1);
    sel = 1'b0; mem_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_val(tag, d, exp);
  endtask

  // Drives start, ndata data bits LSB first, then (if complete) stop and one idle bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div, input int ndata);
    @(negedge clk);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < ndata; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    if (ndata == 8) begin
      rx = stop_bit;
      repeat (div) @(negedge clk);
      rx = 1'b1;
      repeat (div) @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check_val("rst_ready", {31'h0, mem_ready}, 32'h0);
    check_val("rst_irq",   {31'h0, irq},       32'h0);
    check_val("rst_rdata", mem_rdata,          32'h0);
    @(negedge clk); resetn = 1'b1;
    read_check("rst_status", 4'h4, 32'h0);
    read_check("rst_div",    4'h8, 32'd16);

    // Single byte at DIV=16
    send_frame(8'h55, 1'b1, 16, 8);
    check_val("b55_irq", {31'h0, irq}, 32'h1);
    read_check("b55_status", 4'h4, 32'h0000_0011);
    read_check("b55_data",   4'h0, 32'h0000_0055);
    read_check("b55_status2", 4'h4, 32'h0);
    check_val("b55_irq_clr", {31'h0, irq}, 32'h0);

    // Empty read with exact acknowledge timing
    @(negedge clk);
    sel = 1'b1; mem_addr = 4'h0; mem_wstrb = 4'h0;
    #1 check_val("empty_rdy_before", {31'h0, mem_ready}, 32'h0);
    @(posedge clk); #1;
    check_val("empty_rdy", {31'h0, mem_ready}, 32'h1);
    check_val("empty_data", mem_rdata, 32'hFFFF_FFFF);
    sel = 1'b0;
    @(posedge clk); #1;
    check_val("empty_rdy_after", {31'h0, mem_ready}, 32'h0);
    read_check("empty_status", 4'h4, 32'h0);
    read_check("reg_c", 4'hC, 32'h0);

    // Overrun: nine bytes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 16, 8);
    read_check("ovr_status", 4'h4, 32'h0000_0083);
    for (int i = 1; i <= 8; i++) read_check($sformatf("ovr_data%0d", i), 4'h0, 32'(i));
    read_check("ovr_empty", 4'h0, 32'hFFFF_FFFF);
    read_check("ovr_sticky", 4'h4, 32'h0000_0002);
    bus_write(4'h4, 32'h0000_0002);
    read_check("ovr_cleared", 4'h4, 32'h0);

    // Frame error, then recovery
    send_frame(8'hA5, 1'b0, 16, 8);
    read_check("ferr_status", 4'h4, 32'h0000_0004);
    send_frame(8'h3C, 1'b1, 16, 8);
    read_check("ferr_status2", 4'h4, 32'h0000_0015);
    read_check("ferr_data", 4'h0, 32'h0000_003C);
    bus_write(4'h4, 32'h0000_0004);
    read_check("ferr_cleared", 4'h4, 32'h0);

    // Start-bit glitch
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    read_check("glitch_status", 4'h4, 32'h0);
    check_val("glitch_irq", {31'h0, irq}, 32'h0);

    // DIV clamp, then a frame at the minimum period
    bus_write(4'h8, 32'h0000_0002);
    read_check("div_clamp", 4'h8, 32'h0000_0004);
    send_frame(8'hC3, 1'b1, 4, 8);
    read_check("div4_data", 4'h0, 32'h0000_00C3);

    // Reset mid-frame with two bytes queued
    send_frame(8'h11, 1'b1, 4, 8);
    send_frame(8'h22, 1'b1, 4, 8);
    read_check("pre_rst_status", 4'h4, 32'h0000_0021);
    send_frame(8'h99, 1'b1, 4, 4);
    resetn = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mrst_irq",   {31'h0, irq},       32'h0);
    check_val("mrst_ready", {31'h0, mem_ready}, 32'h0);
    check_val("mrst_rdata", mem_rdata,          32'h0);
    resetn = 1'b1;
    read_check("mrst_status", 4'h4, 32'h0);
    read_check("mrst_div",    4'h8, 32'd16);
    send_frame(8'h7E, 1'b1, 16, 8);
    read_check("mrst_status2", 4'h4, 32'h0000_0011);
    read_check("mrst_data",    4'h0, 32'h0000_007E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
